// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: FSM states,
// opcode class field values and datapath mux select codes.
package cpu_pkg;

    // State encodings are visible on the debug 'state' port, so the values are fixed.
    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_INT    = 4'd6,
        ST_HALT   = 4'd7,
        ST_FAULT  = 4'd8
    } state_t;

    // Opcode class field (top two opcode bits). The all-ones opcode is HALT
    // regardless of its class bits.
    localparam logic [1:0] CLASS_ALU    = 2'b00;
    localparam logic [1:0] CLASS_LOAD   = 2'b01;
    localparam logic [1:0] CLASS_STORE  = 2'b10;
    localparam logic [1:0] CLASS_BRANCH = 2'b11;

    // PC input select.
    localparam logic [1:0] PC_MUX_INC    = 2'd0;  // PC + 1
    localparam logic [1:0] PC_MUX_BRANCH = 2'd1;  // ALU_out (branch target)
    localparam logic [1:0] PC_MUX_VEC    = 2'd2;  // interrupt vector

    // Memory address select.
    localparam logic ADDR_MUX_PC  = 1'b0;
    localparam logic ADDR_MUX_ALU = 1'b1;

    // Register write-back source select.
    localparam logic DIN_MUX_ALU = 1'b0;
    localparam logic DIN_MUX_MEM = 1'b1;

    // FETCH and MEM are the only states that hold a memory request open.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// Counts consecutive not-ready memory cycles and flags when the tolerated
// limit is reached. A LIMIT of 0 disables the timeout entirely.
module wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    // At least one bit so a disabled (LIMIT = 0) timer still elaborates.
    localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    // Counter: clear has priority; saturates at the limit so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT_C)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && (count == LIMIT_C);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit CPU. Drives datapath
// register strobes and mux selects, runs the memory handshake with a
// bounded wait count, and handles HALT, level interrupts and bus faults.
//
// Memory handshake: mem_req acts as 'valid'. It rises on entry to FETCH or
// MEM and stays high until the cycle in which mem_ready is sampled high; the
// transfer completes on the rising edge where mem_req && mem_ready. The
// address select and mem_write do not change while the request is open.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_SIZE = 5,
    parameter int unsigned WAIT_LIMIT  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic                   cond_true,
    input  logic                   mem_ready,
    input  logic                   irq,
    input  logic                   irq_enable,
    output logic                   mem_req,
    output logic                   mem_write,
    output logic                   memory_addr_mux,
    output logic [1:0]             PC_mux,
    output logic                   data_in_mux,
    output logic                   IR_write,
    output logic                   PC_write,
    output logic                   reg_buff_write,
    output logic                   ALU_out_write,
    output logic                   status_reg_write,
    output logic                   reg_write,
    output logic                   epc_write,
    output logic                   halted,
    output logic                   bus_error,
    output logic [3:0]             state
);

    state_t     state_q;
    state_t     state_d;
    state_t     eoi_state;
    logic       run_q;
    logic [1:0] op_class;
    logic       is_halt;
    logic       irq_take;
    logic       in_wait;
    logic       wt_clear;
    logic       wt_inc;
    logic       wt_expired;

    assign op_class  = opcode[OPCODE_SIZE-1 -: 2];
    assign is_halt   = &opcode;
    assign irq_take  = irq && irq_enable;
    assign eoi_state = irq_take ? ST_INT : ST_FETCH;
    assign state     = state_q;

    // The counter only runs while a request is open; any other state or a
    // completed transfer zeroes it, so every FETCH/MEM starts from 0.
    assign in_wait  = is_wait_state(state_q);
    assign wt_clear = !in_wait || mem_ready;
    assign wt_inc   = in_wait && !mem_ready;

    wait_timer #(
        .LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wt_clear),
        .inc     (wt_inc),
        .expired (wt_expired)
    );

    // Reset-release marker: holds RESET for one extra edge after rst_n rises,
    // so the first FETCH lands on the second rising edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State register; asynchronous reset drops straight back to RESET.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; every output defaults to 0 each cycle.
    always_comb begin
        state_d          = state_q;
        mem_req          = 1'b0;
        mem_write        = 1'b0;
        memory_addr_mux  = ADDR_MUX_PC;
        PC_mux           = PC_MUX_INC;
        data_in_mux      = DIN_MUX_ALU;
        IR_write         = 1'b0;
        PC_write         = 1'b0;
        reg_buff_write   = 1'b0;
        ALU_out_write    = 1'b0;
        status_reg_write = 1'b0;
        reg_write        = 1'b0;
        epc_write        = 1'b0;
        halted           = 1'b0;
        bus_error        = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = run_q ? ST_FETCH : ST_RESET;
            end

            ST_FETCH: begin
                mem_req         = 1'b1;
                memory_addr_mux = ADDR_MUX_PC;
                if (mem_ready) begin
                    IR_write = 1'b1;
                    PC_write = 1'b1;
                    PC_mux   = PC_MUX_INC;
                    state_d  = ST_DECODE;
                end else if (wt_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_DECODE: begin
                reg_buff_write = 1'b1;
                state_d        = is_halt ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                ALU_out_write = 1'b1;
                case (op_class)
                    CLASS_ALU: begin
                        status_reg_write = 1'b1;
                        state_d          = ST_WB;
                    end
                    CLASS_LOAD, CLASS_STORE: begin
                        state_d = ST_MEM;
                    end
                    default: begin
                        // BRANCH: the target is taken only when the datapath
                        // condition holds this cycle.
                        PC_write = cond_true;
                        PC_mux   = PC_MUX_BRANCH;
                        state_d  = eoi_state;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req         = 1'b1;
                memory_addr_mux = ADDR_MUX_ALU;
                mem_write       = (op_class == CLASS_STORE);
                if (mem_ready) begin
                    state_d = (op_class == CLASS_LOAD) ? ST_WB : eoi_state;
                end else if (wt_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_WB: begin
                reg_write   = 1'b1;
                data_in_mux = (op_class == CLASS_LOAD) ? DIN_MUX_MEM : DIN_MUX_ALU;
                state_d     = eoi_state;
            end

            ST_INT: begin
                // Single cycle: save the return PC and vector; irq is not
                // re-examined until the next instruction completes.
                epc_write = 1'b1;
                PC_write  = 1'b1;
                PC_mux    = PC_MUX_VEC;
                state_d   = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
                if (irq_take) begin
                    state_d = ST_INT;
                end
            end

            ST_FAULT: begin
                // Sticky until rst_n.
                bus_error = 1'b1;
            end

            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised multi-cycle instruction sequencer, the next-generation control unit for the 16-bit CPU. It drives the datapath's register-write strobes and mux selects from a one-hot-free encoded state machine. It adds what the current control path lacks: a ready-handshaked memory port with bounded wait states, an asynchronous reset, a HALT state, a level interrupt with EPC save, and a sticky bus-fault state. Sits between `datapath` and the CPU top, replacing `control_unit`.

## Interface
- `OPCODE_SIZE`, 5: opcode width from IR; `[OPCODE_SIZE-1:OPCODE_SIZE-2]` is the class field.
- `WAIT_LIMIT`, 15: max consecutive not-ready memory cycles tolerated; 0 disables the timeout.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input OPCODE_SIZE: current IR opcode.
- `cond_true` input 1: branch condition evaluated by datapath from status_reg.
- `mem_ready` input 1: memory completes current request this cycle.
- `irq` input 1: level interrupt request.
- `irq_enable` input 1: interrupt mask (1 = enabled).
- `mem_req` output 1: memory access active.
- `mem_write` output 1: access is a store (valid only with mem_req).
- `memory_addr_mux` output 1: 0 = PC, 1 = ALU_out.
- `PC_mux` output 2: 0 = PC+1, 1 = ALU_out (branch target), 2 = interrupt vector.
- `data_in_mux` output 1: register write-back source, 0 = ALU_out, 1 = memory_in.
- `IR_write`, `PC_write`, `reg_buff_write`, `ALU_out_write`, `status_reg_write`, `reg_write`, `epc_write` output 1 each: datapath register strobes.
- `halted` output 1: in HALT. `bus_error` output 1: in FAULT (sticky).
- `state` output 4: current state encoding, for debug.

## Operation
- Classes: 00 ALU, 01 LOAD, 10 STORE, 11 BRANCH; all-ones opcode = HALT (overrides class).
- States: RESET(0), FETCH(1), DECODE(2), EXEC(3), MEM(4), WB(5), INT(6), HALT(7), FAULT(8).
- RESET → FETCH unconditionally; all outputs 0.
- FETCH: mem_req=1, addr_mux=0. On mem_ready: IR_write=1, PC_write=1, PC_mux=0 → DECODE. Else stay.
- DECODE: reg_buff_write=1. HALT opcode → HALT; else → EXEC.
- EXEC: ALU_out_write=1. ALU class also status_reg_write=1 → WB. LOAD/STORE → MEM. BRANCH: PC_write=cond_true, PC_mux=1 → end-of-instruction.
- MEM: mem_req=1, addr_mux=1, mem_write=(STORE). On mem_ready: LOAD → WB; STORE → end-of-instruction. Else stay.
- WB: reg_write=1, data_in_mux=(LOAD) → end-of-instruction.
- End-of-instruction: irq && irq_enable → INT, else → FETCH.
- INT: epc_write=1, PC_write=1, PC_mux=2 → FETCH. Exactly one cycle; irq not re-checked until next instruction end.
- HALT: halted=1, no strobes; irq && irq_enable → INT, else stay.
- Wait counter: clears on entering FETCH/MEM and on mem_ready; increments each not-ready cycle in FETCH/MEM. mem_ready=0 with count==WAIT_LIMIT (WAIT_LIMIT≠0) → FAULT. mem_ready=1 always wins on the limit cycle.
- FAULT: bus_error=1, all other outputs 0; exit only via rst_n.

## Timing
- All outputs combinational from state register, plus mem_ready for FETCH strobes and MEM next-state; cond_true/opcode sampled in the stated cycle.
- Zero-wait latency: ALU 4, LOAD 5, STORE 4, BRANCH 3 cycles; each wait cycle adds 1. INT adds 1.
- Reset assertion mid-instruction: state → RESET immediately (async), counter → 0, all outputs 0 in the same cycle; first FETCH is the 2nd rising edge after release.
- mem_req held stable from entry until mem_ready; mem_write/addr_mux stable throughout.

## Structure
- `cpu_pkg`: state encodings, opcode class constants, HALT opcode, PC_mux/memory_addr_mux/data_in_mux codes.
- One sub-module: `wait_timer` (clear/increment counter, `$clog2(WAIT_LIMIT+1)` bits, `expired` output); the sequencer owns the FSM.

## Test plan
- Reset: rst_n low mid-MEM → state=0, mem_req=0, bus_error=0 immediately; FETCH with mem_req=1 on 2nd edge after release.
- ALU opcode 5'b00010, mem_ready=1 → states 1,2,3,5 then 1; status_reg_write and reg_write each one cycle.
- LOAD with 3 wait cycles in MEM → mem_req high 4 cycles, addr_mux=1, WB with data_in_mux=1; total 8 cycles.
- BRANCH with cond_true=0 then 1 → PC_write in EXEC 0 then 1 with PC_mux=1; 3 cycles each.
- HALT opcode 5'b11111, irq=1 with irq_enable=0 for 10 cycles → halted stays 1; set irq_enable=1 → INT one cycle (epc_write=1, PC_mux=2) → FETCH.
- WAIT_LIMIT=15, mem_ready held 0 in FETCH → FAULT after the 16th not-ready cycle, bus_error=1 sticky; mem_ready=1 on that 16th cycle instead → DECODE, no fault.
